// File: rtl/updown_pkg.sv
// Shared types and segment codes for the up/down game judge.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package updown_pkg;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0,
        R_UP   = 3'd1,
        R_DOWN = 3'd2,
        R_HIT  = 3'd3,
        R_ERR  = 3'd4
    } result_t;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_U    = 7'b0111110;
    localparam logic [6:0] SEG_D    = 7'b1011110;
    localparam logic [6:0] SEG_C    = 7'b0111001;
    localparam logic [6:0] SEG_L    = 7'b0111000;
    localparam logic [6:0] SEG_E    = 7'b1111001;

endpackage

// File: rtl/updown_judge_if.sv
// Guess/judge bundle between debounce logic, RNG and the display mux.
// UPDOWN_BEST_SCORE_EN adds the best_tries field.
interface updown_judge_if #(
    parameter int NUM_W     = 7,
    parameter int MAX_TRIES = 7
) ();
    import updown_pkg::*;

    localparam int TW = $clog2(MAX_TRIES + 1);

    logic             guess_trigger;
    logic             new_game;
    logic [NUM_W-1:0] user_number;
    logic [NUM_W-1:0] actual_number;
    logic [6:0]       seg_display;
    result_t          result;
    logic [TW-1:0]    tries_used;
    logic             game_over;
    logic             win;
`ifdef UPDOWN_BEST_SCORE_EN
    logic [TW-1:0]    best_tries;
`endif

    modport master (
        output guess_trigger, new_game, user_number, actual_number,
`ifdef UPDOWN_BEST_SCORE_EN
        input  best_tries,
`endif
        input  seg_display, result, tries_used, game_over, win
    );

    modport slave (
        input  guess_trigger, new_game, user_number, actual_number,
`ifdef UPDOWN_BEST_SCORE_EN
        output best_tries,
`endif
        output seg_display, result, tries_used, game_over, win
    );

endinterface

// File: rtl/updown_seg_decoder.sv
// Maps (game state, last judgement) to a one-digit 7-segment hint.
// Latency: combinational. Backpressure: none.
module updown_seg_decoder
    import updown_pkg::*;
(
    input  state_t     state,
    input  result_t    result,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (state)
            WIN:  seg = SEG_C;
            LOSE: seg = SEG_L;
            default: begin
                case (result)
                    R_UP:    seg = SEG_U;
                    R_DOWN:  seg = SEG_D;
                    R_HIT:   seg = SEG_C;
                    R_ERR:   seg = SEG_E;
                    default: seg = SEG_DASH;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/updown_judge.sv
// Up/down game judge: edge-triggered guesses, try counting, PLAY/WIN/LOSE FSM, 7-seg hint.
// Latency: 1 cycle from detected trigger edge to all outputs. Backpressure: none.
// UPDOWN_BEST_SCORE_EN adds best_tries, the fewest tries of any win since reset.
module updown_judge
    import updown_pkg::*;
#(
    parameter int NUM_W      = 7,
    parameter int MAX_NUMBER = 99,
    parameter int MAX_TRIES  = 7
) (
    input  logic          clk,
    input  logic          reset,
    updown_judge_if.slave bus
);

    localparam int              TW         = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   TRIES_MAX  = TW'(MAX_TRIES);
    localparam logic [NUM_W:0]  NUMBER_MAX = (NUM_W + 1)'(MAX_NUMBER);

    state_t        state_q, state_nxt;
    result_t       result_q, result_nxt;
    logic [TW-1:0] tries_q, tries_nxt;
    logic [6:0]    seg_q, seg_nxt;
    logic          trig_q;
    logic          over_q;
    logic          win_q;
    logic          fire;

    assign fire = bus.guess_trigger & ~trig_q;

    always_comb begin
        state_nxt  = state_q;
        result_nxt = result_q;
        tries_nxt  = tries_q;
        if (bus.new_game) begin
            state_nxt  = PLAY;
            result_nxt = R_IDLE;
            tries_nxt  = '0;
        end else if (fire && state_q == PLAY) begin
            if ({1'b0, bus.user_number} > NUMBER_MAX) begin
                result_nxt = R_ERR;
            end else begin
                if (tries_q != TRIES_MAX) tries_nxt = tries_q + 1'b1;
                if (bus.user_number == bus.actual_number) begin
                    result_nxt = R_HIT;
                    state_nxt  = WIN;
                end else begin
                    result_nxt = (bus.user_number < bus.actual_number) ? R_UP : R_DOWN;
                    if (tries_nxt == TRIES_MAX) state_nxt = LOSE;
                end
            end
        end
    end

    // Decode the next state so the registered hint lands on the same edge as the judgement.
    updown_seg_decoder u_seg (
        .state  (state_nxt),
        .result (result_nxt),
        .seg    (seg_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            result_q <= R_IDLE;
            tries_q  <= '0;
            seg_q    <= SEG_DASH;
            trig_q   <= 1'b0;
            over_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            result_q <= result_nxt;
            tries_q  <= tries_nxt;
            seg_q    <= seg_nxt;
            trig_q   <= bus.guess_trigger;
            over_q   <= (state_nxt != PLAY);
            win_q    <= (state_nxt == WIN);
        end
    end

    assign bus.seg_display = seg_q;
    assign bus.result      = result_q;
    assign bus.tries_used  = tries_q;
    assign bus.game_over   = over_q;
    assign bus.win         = win_q;

`ifdef UPDOWN_BEST_SCORE_EN
    // "None" is MAX_TRIES+1, clipped when it does not fit the field.
    localparam int            BEST_NONE_I = (MAX_TRIES + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : MAX_TRIES + 1;
    localparam logic [TW-1:0] BEST_NONE   = TW'(BEST_NONE_I);

    logic [TW-1:0] best_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            best_q <= BEST_NONE;
        end else if (state_nxt == WIN && state_q != WIN && tries_nxt < best_q) begin
            best_q <= tries_nxt;
        end
    end

    assign bus.best_tries = best_q;
`endif

endmodule

// File: tb/tb_updown_judge.sv
// Bench for updown_judge: vector table plus hand sequences, scoreboard of expected outputs.
module tb_updown_judge;

    localparam int NUM_W      = 7;
    localparam int MAX_NUMBER = 99;
    localparam int MAX_TRIES  = 7;

    localparam logic [6:0] S_DASH = 7'b1000000;
    localparam logic [6:0] S_U    = 7'b0111110;
    localparam logic [6:0] S_D    = 7'b1011110;
    localparam logic [6:0] S_C    = 7'b0111001;
    localparam logic [6:0] S_L    = 7'b0111000;
    localparam logic [6:0] S_E    = 7'b1111001;

    localparam int R_IDLE_C = 0;
    localparam int R_UP_C   = 1;
    localparam int R_DOWN_C = 2;
    localparam int R_HIT_C  = 3;
    localparam int R_ERR_C  = 4;

    typedef enum int {OP_GUESS, OP_NEW, OP_NEWGUESS} op_t;

    typedef struct {
        int         r;
        int         t;
        logic [6:0] seg;
        bit         ov;
        bit         w;
    } exp_t;

    typedef struct {
        op_t  op;
        int   num;
        int   hold;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    updown_judge_if #(.NUM_W(NUM_W), .MAX_TRIES(MAX_TRIES)) bus ();

    updown_judge #(
        .NUM_W      (NUM_W),
        .MAX_NUMBER (MAX_NUMBER),
        .MAX_TRIES  (MAX_TRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mke(int r, int t, logic [6:0] seg, bit ov, bit w);
        exp_t e;
        e.r = r; e.t = t; e.seg = seg; e.ov = ov; e.w = w;
        return e;
    endfunction

    function automatic vec_t mk(op_t op, int num, int hold, int r, int t, logic [6:0] seg, bit ov, bit w);
        vec_t v;
        v.op = op; v.num = num; v.hold = hold;
        v.e = mke(r, t, seg, ov, w);
        return v;
    endfunction

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty, got nothing to compare", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".result"},    int'(bus.result),      e.r);
        chk({tag, ".tries"},     int'(bus.tries_used),  e.t);
        chk({tag, ".seg"},       int'(bus.seg_display), int'(e.seg));
        chk({tag, ".game_over"}, int'(bus.game_over),   int'(e.ov));
        chk({tag, ".win"},       int'(bus.win),         int'(e.w));
    endtask

    // Every op starts and ends just after a falling edge.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        case (v.op)
            OP_GUESS: begin
                bus.user_number   = 7'(v.num);
                bus.guess_trigger = 1'b1;
                sb_q.push_back(v.e);
                @(negedge clk);
                sb_check(tag);
                if (v.hold > 0) begin
                    sb_q.push_back(v.e);
                    repeat (v.hold) @(negedge clk);
                    sb_check({tag, "_held"});
                end
                bus.guess_trigger = 1'b0;
                @(negedge clk);
            end
            OP_NEW: begin
                bus.new_game = 1'b1;
                sb_q.push_back(v.e);
                @(negedge clk);
                bus.new_game = 1'b0;
                sb_check(tag);
            end
            default: begin
                bus.new_game      = 1'b1;
                bus.user_number   = 7'(v.num);
                bus.guess_trigger = 1'b1;
                sb_q.push_back(v.e);
                @(negedge clk);
                bus.new_game      = 1'b0;
                bus.guess_trigger = 1'b0;
                sb_check(tag);
                @(negedge clk);
            end
        endcase
    endtask

`ifdef UPDOWN_BEST_SCORE_EN
    // MAX_TRIES+1 = 8 does not fit 3 bits, so "none" is 7.
    localparam int BEST_NONE = 7;

    task automatic guess_raw(input int num);
        bus.user_number   = 7'(num);
        bus.guess_trigger = 1'b1;
        @(negedge clk);
        bus.guess_trigger = 1'b0;
        @(negedge clk);
    endtask

    task automatic new_raw();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic win_in(input int n);
        new_raw();
        for (int i = 0; i < n - 1; i++) guess_raw(10 + i);
        guess_raw(42);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.guess_trigger = 1'b0;
        bus.new_game      = 1'b0;
        bus.user_number   = '0;
        bus.actual_number = 7'd42;

        // Secret is 42 throughout.
        vecs.push_back(mk(OP_GUESS,    10, 0, R_UP_C,   1, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    80, 0, R_DOWN_C, 2, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    42, 0, R_HIT_C,  3, S_C,    1, 1));
        vecs.push_back(mk(OP_GUESS,    10, 0, R_HIT_C,  3, S_C,    1, 1));
        vecs.push_back(mk(OP_NEW,       0, 0, R_IDLE_C, 0, S_DASH, 0, 0));
        vecs.push_back(mk(OP_GUESS,    10, 4, R_UP_C,   1, S_U,    0, 0));
        vecs.push_back(mk(OP_NEW,       0, 0, R_IDLE_C, 0, S_DASH, 0, 0));
        vecs.push_back(mk(OP_GUESS,   120, 0, R_ERR_C,  0, S_E,    0, 0));
        vecs.push_back(mk(OP_GUESS,   100, 0, R_ERR_C,  0, S_E,    0, 0));
        vecs.push_back(mk(OP_GUESS,    10, 0, R_UP_C,   1, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    80, 0, R_DOWN_C, 2, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,     0, 0, R_UP_C,   3, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    99, 0, R_DOWN_C, 4, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    41, 0, R_UP_C,   5, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    43, 0, R_DOWN_C, 6, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    50, 0, R_DOWN_C, 7, S_L,    1, 0));
        vecs.push_back(mk(OP_GUESS,    42, 0, R_DOWN_C, 7, S_L,    1, 0));
        vecs.push_back(mk(OP_NEW,       0, 0, R_IDLE_C, 0, S_DASH, 0, 0));
        vecs.push_back(mk(OP_GUESS,    10, 0, R_UP_C,   1, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    20, 0, R_UP_C,   2, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    30, 0, R_UP_C,   3, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    40, 0, R_UP_C,   4, S_U,    0, 0));
        vecs.push_back(mk(OP_NEWGUESS, 42, 0, R_IDLE_C, 0, S_DASH, 0, 0));
        vecs.push_back(mk(OP_GUESS,    42, 0, R_HIT_C,  1, S_C,    1, 1));
        vecs.push_back(mk(OP_NEW,       0, 0, R_IDLE_C, 0, S_DASH, 0, 0));
        vecs.push_back(mk(OP_GUESS,    10, 0, R_UP_C,   1, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    20, 0, R_UP_C,   2, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    30, 0, R_UP_C,   3, S_U,    0, 0));
        vecs.push_back(mk(OP_GUESS,    50, 0, R_DOWN_C, 4, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    60, 0, R_DOWN_C, 5, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    70, 0, R_DOWN_C, 6, S_D,    0, 0));
        vecs.push_back(mk(OP_GUESS,    42, 0, R_HIT_C,  7, S_C,    1, 1));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(mke(R_IDLE_C, 0, S_DASH, 0, 0));
        sb_check("reset");
        repeat (10) @(negedge clk);
        sb_q.push_back(mke(R_IDLE_C, 0, S_DASH, 0, 0));
        sb_check("reset_idle");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

`ifdef UPDOWN_BEST_SCORE_EN
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("best_reset", int'(bus.best_tries), BEST_NONE);
        win_in(5);
        chk("best_win5", int'(bus.best_tries), 5);
        new_raw();
        chk("best_keep_newgame", int'(bus.best_tries), 5);
        win_in(3);
        chk("best_win3", int'(bus.best_tries), 3);
        win_in(6);
        chk("best_win6", int'(bus.best_tries), 3);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("best_reset2", int'(bus.best_tries), BEST_NONE);
`endif

        // Trigger already high while reset is released fires exactly once.
        reset             = 1'b1;
        bus.user_number   = 7'd10;
        bus.guess_trigger = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.push_back(mke(R_UP_C, 1, S_U, 0, 0));
        @(negedge clk);
        sb_check("rel_edge");
        sb_q.push_back(mke(R_UP_C, 1, S_U, 0, 0));
        repeat (3) @(negedge clk);
        sb_check("rel_held");
        bus.guess_trigger = 1'b0;
        @(negedge clk);

        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
